// File: rtl/store_packer_if.sv
// Store request / memory port bundle for store_packer.
// master drives requests and out_ready; slave is the packer.
interface store_packer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [1:0]  in_size;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [3:0]  out_be;

   modport master (
      output in_valid, in_addr, in_data, in_size, out_ready,
      input  in_ready, out_valid, out_addr, out_data, out_be
   );

   modport slave (
      input  in_valid, in_addr, in_data, in_size, out_ready,
      output in_ready, out_valid, out_addr, out_data, out_be
   );
endinterface

// File: rtl/store_packer.sv
// Packs sb/sh/sw store data into lane-aligned words + byte enables and
// buffers them in a FIFO. Define STORE_ALIGN_CHECK_EN to reject misaligned.
module store_packer #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   store_packer_if.slave    bus,
   output logic [CNT_W-1:0] count,
   output logic             align_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           pk;
   entry_t           head;
   logic             rej;
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             full;
   logic             empty;
   logic             accept;
   logic             push;
   logic             pop;

   assign full   = (count == CNT_W'(DEPTH));
   assign empty  = (count == '0);
   assign accept = bus.in_valid && bus.in_ready;
   assign push   = accept && !rej;
   assign pop    = !empty && bus.out_ready && !flush;
   assign head   = mem[rptr];

   assign bus.in_ready  = !full && !flush;
   assign bus.out_valid = !empty;
   assign bus.out_addr  = empty ? '0 : head.addr;
   assign bus.out_data  = empty ? '0 : head.data;
   assign bus.out_be    = empty ? '0 : head.be;

   // Input packing: lane replication, byte enables, reject detection.
   always_comb begin
      pk.addr = {bus.in_addr[31:2], 2'b00};
      pk.data = bus.in_data;
      pk.be   = 4'b0000;
      rej     = 1'b0;
      unique case (bus.in_size)
         2'b00: begin
            pk.data = {4{bus.in_data[7:0]}};
            pk.be   = 4'b0001 << bus.in_addr[1:0];
         end
         2'b01: begin
            pk.data = {2{bus.in_data[15:0]}};
            pk.be   = bus.in_addr[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_ALIGN_CHECK_EN
            rej     = bus.in_addr[0];
`endif
         end
         2'b10: begin
            pk.be   = 4'b1111;
`ifdef STORE_ALIGN_CHECK_EN
            rej     = (bus.in_addr[1:0] != 2'b00);
`endif
         end
         default: rej = 1'b1;
      endcase
   end

   // Entry storage; validity is tracked by count, so no reset needed.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wptr] <= pk;
   end

   // Pointers, occupancy and the registered reject pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         align_err <= 1'b0;
      end else if (flush) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         align_err <= 1'b0;
      end else begin
         align_err <= accept && rej;
         if (push) wptr <= wptr + PTR_W'(1);
         if (pop)  rptr <= rptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_store_packer.sv
// Self-checking bench for store_packer: directed steps plus random
// traffic against a queue-based reference model.
module tb_store_packer;

   localparam int DEPTH = 2;
   localparam int CNT_W = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } ent_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic [CNT_W-1:0] count;
   logic             align_err;

   store_packer_if bus ();

   store_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .bus       (bus),
      .count     (count),
      .align_err (align_err)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   ent_t q[$];
   logic exp_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic ent_t mk(input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] s);
      ent_t e;
      e.addr = {a[31:2], 2'b00};
      case (s)
         2'd0: begin
            e.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
            e.be   = 4'(1 << a[1:0]);
         end
         2'd1: begin
            e.data = {d[15:0], d[15:0]};
            e.be   = a[1] ? 4'hC : 4'h3;
         end
         default: begin
            e.data = d;
            e.be   = 4'hF;
         end
      endcase
      return e;
   endfunction

   function automatic bit bad(input logic [31:0] a, input logic [1:0] s);
      if (s == 2'd3) return 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
      if (s == 2'd1 && a[0]) return 1'b1;
      if (s == 2'd2 && a[1:0] != 2'd0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   task automatic check_state(input string tag);
      ent_t h;
      h = (q.size() > 0) ? q[0] : '0;
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
      chk({tag, ".count"}, 32'(count), 32'(q.size()));
      chk({tag, ".align_err"}, 32'(align_err), 32'(exp_err));
      chk({tag, ".in_ready"}, 32'(bus.in_ready),
          32'(q.size() < DEPTH && !flush));
      chk({tag, ".out_addr"}, bus.out_addr, h.addr);
      chk({tag, ".out_data"}, bus.out_data, h.data);
      chk({tag, ".out_be"}, 32'(bus.out_be), 32'(h.be));
   endtask

   task automatic cycle(input string tag, input logic v,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input logic ordy,
                        input logic fl);
      bit acc;
      bit rj;
      bus.in_valid  = v;
      bus.in_addr   = a;
      bus.in_data   = d;
      bus.in_size   = s;
      bus.out_ready = ordy;
      flush         = fl;
      acc = v && (q.size() < DEPTH) && !fl;
      rj  = bad(a, s);
      @(posedge clk);
      exp_err = acc && rj;
      if (fl) q.delete();
      else begin
         if (ordy && q.size() > 0) void'(q.pop_front());
         if (acc && !rj) q.push_back(mk(a, d, s));
      end
      #1;
      check_state(tag);
   endtask

   task automatic idle(input string tag, input logic ordy);
      cycle(tag, 1'b0, 32'h0, 32'h0, 2'd0, ordy, 1'b0);
   endtask

   initial begin
      reset         = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_addr   = '0;
      bus.in_data   = '0;
      bus.in_size   = '0;
      bus.out_ready = 1'b0;
      #12;
      check_state("reset");
      chk("reset.in_ready_c", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;

      cycle("sb", 1'b1, 32'h0000_1003, 32'h1234_56AB, 2'd0, 1'b0, 1'b0);
      chk("sb.data_c", bus.out_data, 32'hABAB_ABAB);
      chk("sb.be_c", 32'(bus.out_be), 32'h8);
      chk("sb.addr_c", bus.out_addr, 32'h0000_1000);
      idle("drain0", 1'b1);

      cycle("sh", 1'b1, 32'h2002, 32'hDEAD_BEEF, 2'd1, 1'b0, 1'b0);
      cycle("sw", 1'b1, 32'h2004, 32'h0102_0304, 2'd2, 1'b0, 1'b0);
      chk("full.count_c", 32'(count), 32'd2);
      chk("full.ready_c", 32'(bus.in_ready), 32'd0);
      chk("head1.data_c", bus.out_data, 32'hBEEF_BEEF);
      chk("head1.be_c", 32'(bus.out_be), 32'hC);
      cycle("fullpush", 1'b1, 32'h2008, 32'h5555_5555, 2'd2, 1'b1, 1'b0);
      chk("head2.data_c", bus.out_data, 32'h0102_0304);
      chk("head2.addr_c", bus.out_addr, 32'h0000_2004);
      chk("head2.be_c", 32'(bus.out_be), 32'hF);
      idle("drain1", 1'b1);
      chk("drain1.count_c", 32'(count), 32'd0);

      cycle("one", 1'b1, 32'h100, 32'h11, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle("wrap", 1'b1, 32'h100 + 32'(i), 32'h20 + 32'(i), 2'd0,
               1'b1, 1'b0);
         chk("wrap.count_c", 32'(count), 32'd1);
      end
      idle("drain2", 1'b1);

      cycle("rsv", 1'b1, 32'h4000, 32'h1, 2'd3, 1'b0, 1'b0);
      chk("rsv.err_c", 32'(align_err), 32'd1);
      chk("rsv.count_c", 32'(count), 32'd0);
      idle("rsv_end", 1'b0);
      chk("rsv_end.err_c", 32'(align_err), 32'd0);
      cycle("rsv2a", 1'b1, 32'h4000, 32'h1, 2'd3, 1'b0, 1'b0);
      cycle("rsv2b", 1'b1, 32'h4000, 32'h1, 2'd3, 1'b0, 1'b0);
      chk("rsv2b.err_c", 32'(align_err), 32'd1);
      cycle("mis_sw", 1'b1, 32'h3002, 32'hCAFE_F00D, 2'd2, 1'b0, 1'b0);
      idle("mis_end", 1'b1);

      cycle("f1", 1'b1, 32'h10, 32'h1, 2'd2, 1'b0, 1'b0);
      cycle("f2", 1'b1, 32'h14, 32'h2, 2'd2, 1'b0, 1'b0);
      cycle("flush", 1'b1, 32'h18, 32'h3, 2'd2, 1'b1, 1'b1);
      chk("flush.count_c", 32'(count), 32'd0);
      chk("flush.err_c", 32'(align_err), 32'd0);
      idle("post_flush", 1'b0);
      chk("post_flush.ready_c", 32'(bus.in_ready), 32'd1);

      cycle("r1", 1'b1, 32'h20, 32'h1, 2'd2, 1'b0, 1'b0);
      cycle("r2", 1'b1, 32'h24, 32'h2, 2'd2, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      q.delete();
      exp_err = 1'b0;
      chk("areset.out_valid", 32'(bus.out_valid), 32'd0);
      chk("areset.count", 32'(count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;

      for (int i = 0; i < 400; i++) begin
         cycle("rand", ($urandom_range(0, 3) != 0), $urandom, $urandom,
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
